// File: rtl/dbus_responder.sv
// Data-bus responder for the MIPS32 data port: word-addressed RAM plus an MMIO block
// holding a free-running cycle counter, an LED register and a byte-wide debug FIFO.
module dbus_responder #(
    parameter int RAM_AW     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dce,
    input  logic [31:0] daddr,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dm,
    output logic [15:0] led,
    output logic [7:0]  dbg_data,
    output logic        dbg_valid,
    input  logic        dbg_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [5:0] OFF_CYCLE = 6'h00;
    localparam logic [5:0] OFF_LED   = 6'h01;
    localparam logic [5:0] OFF_TX    = 6'h02;
    localparam logic [5:0] OFF_STAT  = 6'h03;

    logic                rd_en;
    logic                wr_en;
    logic                mmio_sel;
    logic [5:0]          mmio_off;
    logic [RAM_AW-1:0]   ram_idx;
    logic                unused_daddr;

    logic [31:0]         ram_mem [0:(1<<RAM_AW)-1];
    logic [31:0]         ram_rdata_q;

    logic [31:0]         cycle_q, cycle_d;
    logic [31:0]         led_q, led_d;
    logic                ovf_q, ovf_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [FIFO_DEPTH-1:0][7:0] fifo_q, fifo_d;
    logic                ram_sel_q, ram_sel_d;
    logic [31:0]         mmio_rdata_q, mmio_rdata_d;

    logic                fifo_empty;
    logic                fifo_full;
    logic                push_req;
    logic                push_ok;
    logic                pop;
    logic                ovf_clr;
    logic [31:0]         stat_word;

    always_comb begin
        rd_en        = dce && (we == 4'h0);
        wr_en        = dce && (we != 4'h0);
        mmio_sel     = daddr[31];
        mmio_off     = daddr[7:2];
        ram_idx      = daddr[RAM_AW+1:2];
        unused_daddr = ^daddr;
    end

    // RAM array has no reset; the read port is registered so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !mmio_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) ram_mem[ram_idx][8*b +: 8] <= din[8*b +: 8];
            end
        end
        if (rd_en && !mmio_sel) ram_rdata_q <= ram_mem[ram_idx];
    end

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        push_req   = wr_en && mmio_sel && (mmio_off == OFF_TX) && we[0];
        pop        = !fifo_empty && dbg_ready;
        // A pop in the same cycle frees the slot a push into a full FIFO needs.
        push_ok    = push_req && (!fifo_full || pop);
        ovf_clr    = wr_en && mmio_sel && (mmio_off == OFF_STAT) && we[0] && din[2];
        stat_word  = {24'h0, 4'(count_q), 1'b0, ovf_q, fifo_full, fifo_empty};

        cycle_d = cycle_q + 32'd1;

        led_d = led_q;
        if (wr_en && mmio_sel && (mmio_off == OFF_LED)) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) led_d[8*b +: 8] = din[8*b +: 8];
            end
        end

        fifo_d = fifo_q;
        if (push_ok) fifo_d[wr_ptr_q] = din[7:0];
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ovf_d = (ovf_q && !ovf_clr) || (push_req && !push_ok);

        ram_sel_d    = ram_sel_q;
        mmio_rdata_d = mmio_rdata_q;
        if (rd_en) begin
            ram_sel_d = !mmio_sel;
            if (mmio_sel) begin
                case (mmio_off)
                    OFF_CYCLE: mmio_rdata_d = cycle_q;
                    OFF_LED:   mmio_rdata_d = led_q;
                    OFF_STAT:  mmio_rdata_d = stat_word;
                    default:   mmio_rdata_d = 32'h0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q      <= '0;
            led_q        <= '0;
            ovf_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fifo_q       <= '0;
            ram_sel_q    <= 1'b0;
            mmio_rdata_q <= '0;
        end else begin
            cycle_q      <= cycle_d;
            led_q        <= led_d;
            ovf_q        <= ovf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fifo_q       <= fifo_d;
            ram_sel_q    <= ram_sel_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    // dm tracks whichever region the most recent read targeted.
    always_comb begin
        dm        = ram_sel_q ? ram_rdata_q : mmio_rdata_q;
        led       = led_q[15:0];
        dbg_valid = !fifo_empty;
        dbg_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: directed scenarios then random bus traffic, all checked
// against a queue/array reference model of the memory map.
module tb_dbus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dce;
    logic [31:0] daddr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dm;
    logic [15:0] led;
    logic [7:0]  dbg_data;
    logic        dbg_valid;
    logic        dbg_ready;

    dbus_responder #(.RAM_AW(10), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dce       (dce),
        .daddr     (daddr),
        .we        (we),
        .din       (din),
        .dm        (dm),
        .led       (led),
        .dbg_data  (dbg_data),
        .dbg_valid (dbg_valid),
        .dbg_ready (dbg_ready)
    );

    always #5 clk = ~clk;

    logic [31:0] m_ram [0:1023];
    logic [31:0] m_dm;
    logic [31:0] m_led;
    logic [31:0] m_cycle;
    bit          m_ovf;
    logic [7:0]  fq[$];
    logic [7:0]  got_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] w);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_stat();
        int n = fq.size();
        return 32'(n * 16 + (m_ovf ? 4 : 0) + (n == 4 ? 2 : 0) + (n == 0 ? 1 : 0));
    endfunction

    task automatic model_reset();
        m_dm = 0; m_led = 0; m_cycle = 0; m_ovf = 0;
        fq.delete();
    endtask

    task automatic step();
        logic [5:0]  off;
        int unsigned idx;
        bit          pop, push, clr, full0;
        logic [31:0] stat;
        if (dbg_valid && dbg_ready) got_q.push_back(dbg_data);
        if (rst_n) begin
            off   = daddr[7:2];
            idx   = daddr[11:2];
            stat  = model_stat();
            full0 = (fq.size() == 4);
            pop   = dbg_ready && (fq.size() > 0);
            push  = 0;
            clr   = 0;
            if (dce && we == 4'h0) begin
                if (!daddr[31]) m_dm = m_ram[idx];
                else begin
                    case (off)
                        6'd0:    m_dm = m_cycle;
                        6'd1:    m_dm = m_led;
                        6'd3:    m_dm = stat;
                        default: m_dm = 0;
                    endcase
                end
            end else if (dce) begin
                if (!daddr[31])     m_ram[idx] = merge(m_ram[idx], din, we);
                else if (off == 1)  m_led = merge(m_led, din, we);
                else if (off == 2)  push = we[0];
                else if (off == 3)  clr = we[0] && din[2];
            end
            if (clr) m_ovf = 0;
            if (pop) void'(fq.pop_front());
            if (push) begin
                if (!full0 || pop) fq.push_back(din[7:0]);
                else m_ovf = 1;
            end
            m_cycle++;
        end
        @(posedge clk);
        #1;
        chk("dm", dm, m_dm);
        chk("led", {16'h0, led}, {16'h0, m_led[15:0]});
        chk("dbg_valid", {31'h0, dbg_valid}, {31'h0, fq.size() > 0});
        chk("dbg_data", {24'h0, dbg_data}, {24'h0, (fq.size() > 0) ? fq[0] : 8'h00});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        dce = 1; daddr = a; din = d; we = w;
        step();
        dce = 0; we = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        dce = 1; daddr = a; we = 0;
        step();
        v = dm;
        dce = 0;
    endtask

    initial begin
        logic [31:0] v1, v2, hi;
        logic [5:0]  off;
        int          op;

        rst_n = 0; dce = 0; daddr = 0; we = 0; din = 0; dbg_ready = 0;
        model_reset();
        step();
        step();
        rst_n = 1;
        chk("reset_dm", dm, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);

        rd(32'h8000_0000, v1);
        for (int i = 0; i < 4; i++) step();
        rd(32'h8000_0000, v2);
        chk("cycle_delta", v2 - v1, 32'd5);

        wr(32'h0000_0010, 32'h1122_3344, 4'hF);
        wr(32'h0000_0010, 32'h0000_AA00, 4'h2);
        rd(32'h0000_0010, v1);
        chk("ram_byte_lane", v1, 32'h1122_AA44);
        wr(32'h0000_1010, 32'hCAFE_F00D, 4'hF);
        rd(32'h0000_0010, v1);
        chk("ram_alias", v1, 32'hCAFE_F00D);

        dbg_ready = 0;
        for (int i = 0; i < 4; i++) wr(32'h8000_0008, 32'h41 + i, 4'h1);
        rd(32'h8000_000C, v1);
        chk("stat_full", v1, 32'h42);
        wr(32'h8000_0008, 32'h45, 4'h1);
        rd(32'h8000_000C, v1);
        chk("stat_ovf", v1, 32'h46);
        got_q.delete();
        dbg_ready = 1;
        for (int i = 0; i < 20 && dbg_valid; i++) step();
        chk("drain_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("drain_order", {24'h0, got_q[i]}, 32'h41 + i);
        chk("drain_empty", {31'h0, dbg_valid}, 32'h0);
        rd(32'h8000_000C, v1);
        chk("stat_empty_ovf", v1, 32'h05);
        wr(32'h8000_000C, 32'h4, 4'h1);
        rd(32'h8000_000C, v1);
        chk("stat_ovf_clear", v1, 32'h01);

        dbg_ready = 0;
        for (int i = 0; i < 4; i++) wr(32'h8000_0008, 32'h51 + i, 4'h1);
        got_q.delete();
        dbg_ready = 1;
        wr(32'h8000_0008, 32'h55, 4'h1);
        dbg_ready = 0;
        rd(32'h8000_000C, v1);
        chk("stat_push_pop_full", v1, 32'h42);
        dbg_ready = 1;
        for (int i = 0; i < 20 && dbg_valid; i++) step();
        chk("pp_count", got_q.size(), 5);
        if (got_q.size() > 0) chk("pp_last", {24'h0, got_q[$]}, 32'h55);
        dbg_ready = 0;

        wr(32'h8000_0004, 32'hDEAD_BEEF, 4'h3);
        chk("led_write", {16'h0, led}, 32'h0000_BEEF);
        rd(32'h8000_0004, v1);
        chk("led_read", v1, 32'h0000_BEEF);
        rd(32'h8000_0040, v1);
        chk("unmapped_read", v1, 32'h0);

        for (int i = 0; i < 3; i++) wr(32'h8000_0008, 32'h61 + i, 4'h1);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_valid", {31'h0, dbg_valid}, 32'h0);
        chk("async_rst_data", {24'h0, dbg_data}, 32'h0);
        chk("async_rst_led", {16'h0, led}, 32'h0);
        model_reset();
        step();
        rst_n = 1;
        rd(32'h8000_000C, v1);
        chk("stat_after_rst", v1, 32'h01);
        chk("led_after_rst", {16'h0, led}, 32'h0);

        for (int i = 0; i < 16; i++) wr(32'(i) << 2, $urandom, 4'hF);
        for (int n = 0; n < 400; n++) begin
            op        = $urandom_range(0, 9);
            hi        = $urandom;
            dbg_ready = 1'($urandom_range(0, 1));
            din       = $urandom;
            off       = 6'($urandom_range(0, 5));
            if (off == 6'd5) off = 6'($urandom_range(4, 63));
            case (op)
                0, 1: begin dce = 1; we = 4'($urandom_range(1, 15));
                            daddr = (hi & 32'h7FFF_F003) | (32'($urandom_range(0, 15)) << 2); end
                2, 3: begin dce = 1; we = 0;
                            daddr = (hi & 32'h7FFF_F003) | (32'($urandom_range(0, 15)) << 2); end
                4:    begin dce = 1; we = 4'($urandom_range(0, 15));
                            daddr = 32'h8000_0000 | (hi & 32'h7FFF_FF03) | (32'(off) << 2); end
                5, 6: begin dce = 1; we = 4'($urandom_range(0, 15)) | 4'h1;
                            daddr = 32'h8000_0008 | (hi & 32'h7FFF_FF03); end
                7:    begin dce = 1; we = 0;
                            daddr = 32'h8000_0000 | (hi & 32'h7FFF_FF03) | (32'(off) << 2); end
                default: begin dce = 0; we = 4'($urandom_range(0, 15)); daddr = hi; end
            endcase
            step();
        end
        dce = 0; we = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
